// File: rtl/vga_buffer_writer.sv
// -----------------------------------------------------------------------------
// vga_buffer_writer
//
// Write side of a double-buffered VGA frame buffer. Pixels arrive from the PPU
// in raster order over a valid/ready handshake. They are written to the back
// bank with generated row/col addresses. Once a complete frame is written, the
// banks swap, but only while the VGA controller reports it is outside the
// visible area (vga_done).
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   pix_data          colour index from the PPU
//   pix_valid         pix_data is valid this cycle
//   pix_sof           marks pix_data as pixel (0,0) of a frame
//   pix_ready         writer accepts a pixel this cycle (state decode only)
//   vga_done          VGA controller is past the visible region
//   wr_row, wr_col    registered frame buffer write address (zero-extended)
//   wr_data, wr_en    registered write data and one-cycle write strobe
//   wr_bank           bank under write (back bank)
//   rd_bank           bank read by the VGA controller, always ~wr_bank
//   frame_done        one-cycle pulse on bank swap
//   sof_error         one-cycle pulse, aligned with wr_en, on a mid-frame SOF
// -----------------------------------------------------------------------------
module vga_buffer_writer #(
  parameter int H_PIXELS = 256,
  parameter int V_LINES  = 240,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              vga_done,
  output logic [9:0]        wr_row,
  output logic [9:0]        wr_col,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              sof_error
);

  localparam logic [9:0] COL_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0] ROW_LAST = 10'(V_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [9:0]          row_reg, row_next;
  logic [9:0]          col_reg, col_next;
  logic [9:0]          wr_row_reg, wr_row_next;
  logic [9:0]          wr_col_reg, wr_col_next;
  logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
  logic                wr_en_reg, wr_en_next;
  logic                bank_reg, bank_next;
  logic                frame_done_reg, frame_done_next;
  logic                sof_error_reg, sof_error_next;
  logic                accept;

  // Ready depends on state alone so the producer never sees a valid->ready path.
  assign pix_ready = (state_reg != S_WAIT_SWAP);
  assign accept    = pix_valid & pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      wr_row_reg     <= '0;
      wr_col_reg     <= '0;
      wr_data_reg    <= '0;
      wr_en_reg      <= 1'b0;
      bank_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      sof_error_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      wr_row_reg     <= wr_row_next;
      wr_col_reg     <= wr_col_next;
      wr_data_reg    <= wr_data_next;
      wr_en_reg      <= wr_en_next;
      bank_reg       <= bank_next;
      frame_done_reg <= frame_done_next;
      sof_error_reg  <= sof_error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    wr_row_next     = wr_row_reg;
    wr_col_next     = wr_col_reg;
    wr_data_next    = wr_data_reg;
    wr_en_next      = 1'b0;
    bank_next       = bank_reg;
    frame_done_next = 1'b0;
    sof_error_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Pixels without SOF are discarded until a frame start is seen.
        if (accept && pix_sof) begin
          wr_en_next   = 1'b1;
          wr_row_next  = '0;
          wr_col_next  = '0;
          wr_data_next = pix_data;
          row_next     = '0;
          col_next     = 10'd1;
          state_next   = S_WRITE;
        end
      end

      S_WRITE: begin
        if (accept) begin
          wr_en_next   = 1'b1;
          wr_data_next = pix_data;
          if (pix_sof && ((row_reg != '0) || (col_reg != '0))) begin
            // Resync: restart the frame at (0,0). This wins over completion
            // even when the SOF lands on the last pixel position.
            sof_error_next = 1'b1;
            wr_row_next    = '0;
            wr_col_next    = '0;
            row_next       = '0;
            col_next       = 10'd1;
          end else begin
            wr_row_next = row_reg;
            wr_col_next = col_reg;
            if (col_reg == COL_LAST) begin
              col_next = '0;
              if (row_reg == ROW_LAST) begin
                row_next   = '0;
                state_next = S_WAIT_SWAP;
              end else begin
                row_next = row_reg + 10'd1;
              end
            end else begin
              col_next = col_reg + 10'd1;
            end
          end
        end
      end

      S_WAIT_SWAP: begin
        // vga_done is a level; the swap happens on the first cycle it is seen.
        if (vga_done) begin
          bank_next       = ~bank_reg;
          frame_done_next = 1'b1;
          state_next      = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign wr_row     = wr_row_reg;
  assign wr_col     = wr_col_reg;
  assign wr_data    = wr_data_reg;
  assign wr_en      = wr_en_reg;
  assign wr_bank    = bank_reg;
  assign rd_bank    = ~bank_reg;
  assign frame_done = frame_done_reg;
  assign sof_error  = sof_error_reg;

endmodule

// File: tb/tb_vga_buffer_writer.sv
// -----------------------------------------------------------------------------
// tb_vga_buffer_writer
//
// Directed sequence with randomized data and valid gaps. The expected outputs
// come from a frame model that tracks only the linear pixel index within the
// frame. Row and column are derived from that index as idx / H and idx % H.
// -----------------------------------------------------------------------------
module tb_vga_buffer_writer;

  // Reduced frame geometry; non-power-of-two width exercises the line wrap.
  localparam int H    = 24;
  localparam int V    = 10;
  localparam int DW   = 8;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_ready;
  logic          vga_done = 1'b0;
  logic [9:0]    wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic          wr_en, wr_bank, rd_bank, frame_done, sof_error;

  vga_buffer_writer #(.H_PIXELS(H), .V_LINES(V), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .vga_done(vga_done),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_en(wr_en),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_done(frame_done), .sof_error(sof_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame model: m_idx is the next linear pixel index (-1 = no frame open).
  int          m_idx  = -1;
  bit          m_wait = 1'b0;
  bit          m_bank = 1'b0;
  bit          e_en, e_err, e_fd;
  int          e_row, e_col;
  logic [7:0]  e_data;
  int          swaps = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic post_check();
    chk("wr_en", 32'(wr_en), 32'(e_en));
    if (e_en) begin
      chk("wr_row", 32'(wr_row), 32'(e_row));
      chk("wr_col", 32'(wr_col), 32'(e_col));
      chk("wr_data", 32'(wr_data), 32'(e_data));
    end
    chk("sof_error", 32'(sof_error), 32'(e_err));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("wr_bank", 32'(wr_bank), 32'(m_bank));
    chk("rd_bank", 32'(rd_bank), 32'(!m_bank));
  endtask

  task automatic model_write(input int idx, input logic [7:0] d);
    e_en   = 1'b1;
    e_row  = idx / H;
    e_col  = idx % H;
    e_data = d;
  endtask

  // One clock: drive inputs, check ready, predict, advance, check outputs.
  task automatic cyc(input bit v, input bit s, input logic [7:0] d, input bit vd);
    pix_valid = v; pix_sof = s; pix_data = d; vga_done = vd;
    #1;
    chk("pix_ready", 32'(pix_ready), 32'(!m_wait));
    e_en = 1'b0; e_err = 1'b0; e_fd = 1'b0;
    if (m_wait) begin
      if (vd) begin
        m_bank = !m_bank;
        e_fd   = 1'b1;
        m_wait = 1'b0;
        m_idx  = -1;
        swaps++;
      end
    end else if (v) begin
      if (s) begin
        e_err = (m_idx > 0);
        model_write(0, d);
        m_idx = 1;
      end else if (m_idx >= 0) begin
        model_write(m_idx, d);
        m_idx++;
        if (m_idx == NPIX) begin
          m_wait = 1'b1;
          m_idx  = -1;
        end
      end
    end
    @(posedge clk);
    #1;
    post_check();
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic apply_reset();
    pix_valid = 1'b0; pix_sof = 1'b0; vga_done = 1'b0;
    rst = 1'b1;
    #1;
    m_idx = -1; m_wait = 1'b0; m_bank = 1'b0;
    e_en = 1'b0; e_err = 1'b0; e_fd = 1'b0;
    post_check();
    @(posedge clk);
    #1;
    post_check();
    rst = 1'b0;
  endtask

  // Send up to n accepted pixels (stops early when the frame completes).
  task automatic send_pixels(input int n, input int gap_pct, input bit vd, input int resync_at);
    int  k = 0;
    int  guard = 0;
    bit  v, s;
    logic [7:0] d;
    while (k < n && !m_wait && guard < 20 * NPIX) begin
      v = ($urandom_range(99) >= gap_pct);
      s = v && (k == resync_at);
      d = s ? 8'h55 : 8'($urandom);
      cyc(v, s, d, vd);
      if (v) k++;
      guard++;
    end
  endtask

  initial begin
    int sw0;
    apply_reset();

    // Idle drop, then a back-to-back frame starting with SOF data 0xAA.
    repeat (10) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    send_pixels(NPIX, 0, 1'b0, -1);
    repeat (5) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);  // valid ignored in wait
    cyc(1'b0, 1'b0, 8'h00, 1'b1);                     // swap
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("bank_after_frame1", 32'(wr_bank), 32'd1);

    // Mid-frame resync plus random valid gaps, vga_done held high.
    cyc(1'b1, 1'b1, 8'($urandom), 1'b1);
    send_pixels(2 * NPIX, 50, 1'b1, 30);
    cyc(1'b1, 1'b0, 8'($urandom), 1'b1);              // swap right after entry
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-frame, then restart.
    cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
    send_pixels(100, 30, 1'b0, -1);
    apply_reset();
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
    send_pixels(NPIX, 0, 1'b0, -1);

    // Reset while waiting for the swap.
    repeat (3) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    apply_reset();

    // Two frames, each followed by a vga_done pulse.
    sw0 = swaps;
    for (int f = 0; f < 2; f++) begin
      cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
      send_pixels(NPIX, 20, 1'b0, -1);
      repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("bank_two_frames", 32'(wr_bank), 32'((f + 1) % 2));
    end
    chk("swap_count", 32'(swaps - sw0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_buffer_writer.md
# vga_buffer_writer

Write side of the double-buffered VGA frame buffer. Accepts the PPU's 256x240 pixel stream over a valid/ready handshake, generates row/col addresses and write strobes into the back bank, and swaps banks only while the VGA controller is outside the visible area (`vga_done` high). The VGA controller reads the front bank through its row/col/data port.

## Interface
- `H_PIXELS`, 256, pixels per line; column range 0..H_PIXELS-1
- `V_LINES`, 240, lines per frame; row range 0..V_LINES-1
- `DATA_W`, 8, colour-index width; matches the VGA buffer data port

- `clk`  in  1  system clock (single clock domain)
- `rst`  in  1  asynchronous, active-high reset
- `pix_data`  in  DATA_W  colour index from the PPU
- `pix_valid`  in  1  `pix_data` is valid this cycle
- `pix_sof`  in  1  qualifies `pix_data` as pixel (0,0) of a frame
- `pix_ready`  out  1  writer can accept a pixel this cycle
- `vga_done`  in  1  VGA controller is past the visible region; bank swap is safe
- `wr_row`  out  10  frame buffer write row, zero-extended
- `wr_col`  out  10  frame buffer write column, zero-extended
- `wr_data`  out  DATA_W  frame buffer write data
- `wr_en`  out  1  write strobe, one cycle per pixel
- `wr_bank`  out  1  bank being written (back bank)
- `rd_bank`  out  1  bank the VGA controller reads; always `~wr_bank`
- `frame_done`  out  1  one-cycle pulse on bank swap
- `sof_error`  out  1  one-cycle pulse when SOF arrives mid-frame

## Operation
- Accept = `pix_valid & pix_ready`.
- The block has three states: IDLE, WRITE and WAIT_SWAP.
- **IDLE**
  - `pix_ready`=1.
  - An accepted pixel with `pix_sof`=0 is dropped; no write occurs.
  - An accepted pixel with `pix_sof`=1 is written at (0,0). Next state is WRITE with the counters at col=1, row=0.
- **WRITE**
  - `pix_ready`=1.
  - Each accepted pixel is written at the current (row, col), then col increments.
  - When col reaches H_PIXELS-1, col returns to 0 and row increments.
  - An accept at (V_LINES-1, H_PIXELS-1) writes the last pixel and moves to WAIT_SWAP.
  - An accepted pixel with `pix_sof`=1 at any position other than (0,0) pulses `sof_error`. That pixel is written at (0,0) and the counters restart at col=1, row=0 (resync).
  - Gaps in `pix_valid` only stall the counters.
- **WAIT_SWAP**
  - `pix_ready`=0.
  - In the first cycle with `vga_done`=1, `wr_bank` toggles, `frame_done` pulses, and the next state is IDLE.
  - `vga_done` is level-sensitive; if it is already high on entry, the swap happens in the next cycle.
- `rd_bank` = `~wr_bank`, combinational, so the reader never sees the bank under write.
- Counter width is 10 bits. Comparisons use the parameters, so there is no wrap past H_PIXELS-1 / V_LINES-1.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, row=col=0, `wr_bank`=0, `rd_bank`=1.
  - `wr_en`=0, `wr_row`=`wr_col`=0, `wr_data`=0.
  - `frame_done`=0, `sof_error`=0.
  - `pix_ready`=1 once reset deasserts.
- `wr_en`, `wr_row`, `wr_col` and `wr_data` are registered: an accept at edge N drives the write on cycle N+1. Throughput is 1 pixel/clk.
- `sof_error` is registered and aligns with the `wr_en` of the offending pixel.
- `pix_ready` is a combinational decode of state only, with no dependence on `pix_valid`. It drops to 0 in the cycle after the final pixel's accept.
- `frame_done` and the `wr_bank` toggle occur in the same cycle, one edge after `vga_done` is sampled high in WAIT_SWAP. `pix_ready` returns to 1 in that same cycle.
- A full frame needs a minimum of H_PIXELS*V_LINES accept cycles + 1 swap cycle.
- Reset mid-frame or in WAIT_SWAP:
  - The partial frame is abandoned, with no swap and no `frame_done`.
  - `wr_bank` returns to 0.
- Simultaneous events:
  - `pix_sof` on the final pixel position is an error only if that position is not (0,0). The resync takes priority over frame completion.
  - `pix_valid` during WAIT_SWAP is ignored because `pix_ready`=0.

## Test plan
- **Full frame.** Reset, then 61440 back-to-back pixels with data = (index mod 256) and SOF on the first, `vga_done`=0 throughout, then raise `vga_done`.
  - `wr_en` is asserted 61440 times, row 0..239 and col 0..255 in raster order, data matching.
  - `pix_ready`=0 after the last accept.
  - One `frame_done` one cycle after `vga_done` rises; `wr_bank`=1, `rd_bank`=0.
- **Idle drop.** 10 pixels with SOF=0 after reset, then SOF pixel 0xAA.
  - No `wr_en` for the first 10.
  - The first write is (0,0) with data 0xAA.
- **Mid-frame resync.** SOF, 300 pixels, then a pixel 0x55 with SOF=1.
  - `sof_error` pulses once.
  - 0x55 is written at (0,0); the next pixel goes to (0,1).
- **Valid gaps.** Full frame with `pix_valid` toggled randomly (≈50%), `vga_done` high throughout.
  - Same address/data sequence as the full-frame test.
  - Swap occurs the cycle after entering WAIT_SWAP.
- **Reset mid-operation.** Assert `rst` at pixel 1000, and separately in WAIT_SWAP.
  - All outputs go immediately to their reset values, with `wr_bank`=0 and no `frame_done`.
  - The next SOF restarts at (0,0).
- **Two frames.** Two consecutive frames with a `vga_done` pulse after each.
  - `wr_bank` sequence 0→1→0.
  - Two `frame_done` pulses.
  - `rd_bank` is always `~wr_bank`.
